// File: rtl/pwm_gen.sv
// pwm_gen: PWM output stage with double-buffered compare/mode/period shadows,
// registered complementary outputs and a period-boundary pulse. Optional dead-time insertion: PWM_DEADTIME_EN.
module pwm_gen #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_en,
    input  logic [CNT_W-1:0] count_val,
    input  logic [CNT_W-1:0] period,
    input  logic             upnotdown,
    input  logic [CNT_W-1:0] compare1,
    input  logic [CNT_W-1:0] compare2,
    input  logic [1:0]       functions,
`ifdef PWM_DEADTIME_EN
    input  logic [7:0]       dead_time,
`endif
    output logic             pwm_out,
    output logic             pwm_out_n,
    output logic             period_evt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2
`ifdef PWM_DEADTIME_EN
        ,
        ST_DT   = 2'd3
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] prev_cnt_q, prev_cnt_d;
    logic [CNT_W-1:0] cmp1_sh_q, cmp1_sh_d;
    logic [CNT_W-1:0] cmp2_sh_q, cmp2_sh_d;
    logic [CNT_W-1:0] per_sh_q, per_sh_d;
    logic [1:0]       func_sh_q, func_sh_d;
    logic             pwm_out_q, pwm_out_d;
    logic             pwm_out_n_q, pwm_out_n_d;
    logic             period_evt_q, period_evt_d;
`ifdef PWM_DEADTIME_EN
    logic [7:0]       dt_sh_q, dt_sh_d;
    logic [7:0]       dt_cnt_q, dt_cnt_d;
`endif

    logic   cnt_chg_s;
    logic   wrap_s;
    logic   load_s;
    logic   raw_s;
    state_t target_s;

    // Waveform level for one count value under the given mode and compare values.
    function automatic logic raw_level(
        input logic [CNT_W-1:0] cnt,
        input logic [CNT_W-1:0] c1,
        input logic [CNT_W-1:0] c2,
        input logic [1:0]       func
    );
        logic lvl;
        case (func)
            2'b00:   lvl = (cnt < c1);
            2'b01:   lvl = (cnt >= c1);
            2'b10,
            2'b11:   lvl = (cnt >= c1) && (cnt < c2);
            default: lvl = 1'b0;
        endcase
        return lvl;
    endfunction

    // Boundary detection: a wrap needs the count to have actually moved, so prescaler holds are ignored.
    always_comb begin
        prev_cnt_d = count_val;
        cnt_chg_s  = (count_val != prev_cnt_q);
        if (upnotdown) begin
            wrap_s = cnt_chg_s && (count_val == {CNT_W{1'b0}});
        end else begin
            wrap_s = cnt_chg_s && (count_val == per_sh_q);
        end
        load_s       = !pwm_en || wrap_s;
        period_evt_d = pwm_en && wrap_s;
    end

    // Shadow set: transparent while disabled, otherwise refreshed only on a wrap.
    always_comb begin
        if (load_s) begin
            cmp1_sh_d = compare1;
            cmp2_sh_d = compare2;
            per_sh_d  = period;
            func_sh_d = functions;
`ifdef PWM_DEADTIME_EN
            dt_sh_d   = dead_time;
`endif
        end else begin
            cmp1_sh_d = cmp1_sh_q;
            cmp2_sh_d = cmp2_sh_q;
            per_sh_d  = per_sh_q;
            func_sh_d = func_sh_q;
`ifdef PWM_DEADTIME_EN
            dt_sh_d   = dt_sh_q;
`endif
        end
    end

    // Raw compare uses the values the shadows hold for this cycle, so the wrap count
    // itself already belongs to the new period.
    always_comb begin
        raw_s = raw_level(count_val, cmp1_sh_d, cmp2_sh_d, func_sh_d);
        if (raw_s) begin
            target_s = ST_HI;
        end else begin
            target_s = ST_LO;
        end
    end

    // Output state machine: next state and the registered output levels it implies.
    always_comb begin
        state_d  = state_q;
`ifdef PWM_DEADTIME_EN
        dt_cnt_d = dt_cnt_q;
`endif
        if (!pwm_en) begin
            state_d  = ST_IDLE;
`ifdef PWM_DEADTIME_EN
            dt_cnt_d = 8'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = target_s;
                end
                ST_HI,
                ST_LO: begin
                    if (target_s != state_q) begin
`ifdef PWM_DEADTIME_EN
                        if (dt_sh_d == 8'd0) begin
                            state_d = target_s;
                        end else begin
                            state_d  = ST_DT;
                            dt_cnt_d = dt_sh_d;
                        end
`else
                        state_d = target_s;
`endif
                    end else begin
                        state_d = state_q;
                    end
                end
`ifdef PWM_DEADTIME_EN
                // The target tracks raw throughout; the count runs on regardless.
                ST_DT: begin
                    if (dt_cnt_q <= 8'd1) begin
                        state_d  = target_s;
                        dt_cnt_d = 8'd0;
                    end else begin
                        state_d  = ST_DT;
                        dt_cnt_d = dt_cnt_q - 8'd1;
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        pwm_out_d   = (state_d == ST_HI);
        pwm_out_n_d = (state_d == ST_LO);
    end

    // State, shadow and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            prev_cnt_q   <= {CNT_W{1'b0}};
            cmp1_sh_q    <= {CNT_W{1'b0}};
            cmp2_sh_q    <= {CNT_W{1'b0}};
            per_sh_q     <= {CNT_W{1'b0}};
            func_sh_q    <= 2'b00;
            pwm_out_q    <= 1'b0;
            pwm_out_n_q  <= 1'b0;
            period_evt_q <= 1'b0;
`ifdef PWM_DEADTIME_EN
            dt_sh_q      <= 8'd0;
            dt_cnt_q     <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            prev_cnt_q   <= prev_cnt_d;
            cmp1_sh_q    <= cmp1_sh_d;
            cmp2_sh_q    <= cmp2_sh_d;
            per_sh_q     <= per_sh_d;
            func_sh_q    <= func_sh_d;
            pwm_out_q    <= pwm_out_d;
            pwm_out_n_q  <= pwm_out_n_d;
            period_evt_q <= period_evt_d;
`ifdef PWM_DEADTIME_EN
            dt_sh_q      <= dt_sh_d;
            dt_cnt_q     <= dt_cnt_d;
`endif
        end
    end

    assign pwm_out    = pwm_out_q;
    assign pwm_out_n  = pwm_out_n_q;
    assign period_evt = period_evt_q;

endmodule

// File: tb/tb_pwm_gen.sv
// Scoreboard bench for pwm_gen: directed count sequences push the expected outputs,
// a forked monitor pops and compares one cycle later.
module tb_pwm_gen;

    localparam int CNT_W = 16;
    localparam int PER   = 9;

    logic             clk;
    logic             rst_n;
    logic             pwm_en;
    logic [CNT_W-1:0] count_val;
    logic [CNT_W-1:0] period;
    logic             upnotdown;
    logic [CNT_W-1:0] compare1;
    logic [CNT_W-1:0] compare2;
    logic [1:0]       functions;
`ifdef PWM_DEADTIME_EN
    logic [7:0]       dead_time;
`endif
    logic             pwm_out;
    logic             pwm_out_n;
    logic             period_evt;

    typedef struct {
        int cnt;
        bit po;
        bit pon;
        bit evt;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   prev;

    pwm_gen #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_en     (pwm_en),
        .count_val  (count_val),
        .period     (period),
        .upnotdown  (upnotdown),
        .compare1   (compare1),
        .compare2   (compare2),
        .functions  (functions),
`ifdef PWM_DEADTIME_EN
        .dead_time  (dead_time),
`endif
        .pwm_out    (pwm_out),
        .pwm_out_n  (pwm_out_n),
        .period_evt (period_evt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit level(input int c, input int f, input int c1, input int c2);
        if (f == 0) return (c < c1);
        else if (f == 1) return (c >= c1);
        else return (c >= c1) && (c < c2);
    endfunction

    // Drive one count value at the current negedge and queue the outputs expected after the next posedge.
    task automatic step(input int c, input bit po, input bit pon);
        exp_t e;
        bit   wrap;
        count_val = c[CNT_W-1:0];
        wrap = (c != prev) && (upnotdown ? (c == 0) : (c == PER));
        e.cnt = c;
        e.po  = po;
        e.pon = pon;
        e.evt = wrap && pwm_en;
        exp_q.push_back(e);
        prev = c;
        @(negedge clk);
    endtask

    // Enabled run from first to last (either direction) with the given active settings.
    task automatic run(input int first, input int last, input int f, input int c1, input int c2);
        int c;
        bit l;
        c = first;
        forever begin
            l = level(c, f, c1, c2);
            step(c, l, !l);
            if (c == last) break;
            c = (last > first) ? c + 1 : c - 1;
        end
    endtask

    task automatic run_off(input int first, input int last);
        for (int c = first; c <= last; c++) step(c, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0b want %0b", name, act, req);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        prev      = 0;
        rst_n     = 1'b0;
        pwm_en    = 1'b0;
        count_val = '0;
        period    = PER[CNT_W-1:0];
        upnotdown = 1'b1;
        compare1  = 16'd3;
        compare2  = 16'd0;
        functions = 2'd0;
`ifdef PWM_DEADTIME_EN
        dead_time = 8'd0;
`endif
        fork
            forever begin
                exp_t e;
                @(posedge clk);
                #1;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (pwm_out !== e.po || pwm_out_n !== e.pon || period_evt !== e.evt) begin
                        errors++;
                        $display("FAIL out cnt=%0d got po=%0b pon=%0b evt=%0b want po=%0b pon=%0b evt=%0b",
                                 e.cnt, pwm_out, pwm_out_n, period_evt, e.po, e.pon, e.evt);
                    end
                end
            end
        join_none

        repeat (2) @(negedge clk);
        chk("reset_out", pwm_out, 1'b0);
        chk("reset_out_n", pwm_out_n, 1'b0);
        chk("reset_evt", period_evt, 1'b0);
        rst_n = 1'b1;

        // Disabled: idle outputs, no events.
        run_off(0, 9);
        // Enable on the wrap cycle; left-aligned 30 % for two periods.
        pwm_en = 1'b1;
        run(0, 9, 0, 3, 0);
        run(0, 9, 0, 3, 0);

        // Prescaler hold: each count twice, only the first 0 is a boundary.
        for (int c = 0; c <= 9; c++) begin
            step(c, level(c, 0, 3, 0), !level(c, 0, 3, 0));
            step(c, level(c, 0, 3, 0), !level(c, 0, 3, 0));
        end

        // Mid-period compare write stays invisible until the next wrap.
        run(0, 4, 0, 3, 0);
        compare1 = 16'd7;
        run(5, 9, 0, 3, 0);
        run(0, 9, 0, 7, 0);

        // Range mode, then an empty range written mid-period.
        functions = 2'd2;
        compare1  = 16'd2;
        compare2  = 16'd6;
        run(0, 4, 2, 2, 6);
        compare1  = 16'd6;
        compare2  = 16'd2;
        run(5, 9, 2, 2, 6);
        run(0, 9, 2, 6, 2);

        // Boundaries, each written on the wrap cycle.
        functions = 2'd0;
        compare1  = 16'd0;
        run(0, 9, 0, 0, 0);
        compare1  = 16'd10;
        run(0, 9, 0, 10, 0);
        functions = 2'd1;
        compare1  = 16'd0;
        run(0, 9, 1, 0, 0);
        compare1  = 16'd5;
        run(0, 9, 1, 5, 0);

        // Down counting: boundary is at the period value.
        upnotdown = 1'b0;
        functions = 2'd0;
        compare1  = 16'd3;
        run(8, 0, 1, 5, 0);
        run(9, 0, 0, 3, 0);
        upnotdown = 1'b1;
        run(1, 9, 0, 3, 0);

        // Disable mid-high: outputs drop next clock, boundary not flagged.
        run(0, 1, 0, 3, 0);
        pwm_en = 1'b0;
        run_off(2, 9);
        step(0, 1'b0, 1'b0);

        // Re-enable from idle, then asynchronous reset mid-high.
        pwm_en = 1'b1;
        run(1, 2, 0, 3, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out", pwm_out, 1'b0);
        chk("async_rst_out_n", pwm_out_n, 1'b0);
        chk("async_rst_evt", period_evt, 1'b0);
        pwm_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        prev  = 0;
        run_off(3, 5);
        pwm_en = 1'b1;
        run(6, 9, 0, 3, 0);
        run(0, 9, 0, 3, 0);

`ifdef PWM_DEADTIME_EN
        // Dead time 3 with compare 5: both outputs low for 3 clocks around every edge.
        pwm_en    = 1'b0;
        dead_time = 8'd3;
        compare1  = 16'd5;
        step(0, 1'b0, 1'b0);
        pwm_en = 1'b1;
        for (int c = 1; c <= 9; c++) step(c, (c <= 4), (c >= 8));
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c <= 9; c++) step(c, (c == 3 || c == 4), (c >= 8));
        end
`endif

        repeat (2) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
